// File: rtl/screen_flash_fx.sv
// Screen flash post-process: blends the background RGB565 colour toward white
// by a level that rises, holds and fades, stepping only on frame boundaries.
// Latency 1 clk (bg_colour -> oled_colour, registered); no backpressure, streaming every cycle.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   pixel_index          current OLED pixel; a fresh 0 marks a frame boundary
//   bg_colour            RGB565 colour of the current pixel
//   fx_trigger           one-cycle pulse that starts or re-arms the flash
//   oled_colour          blended RGB565 colour (registered)
//   fx_busy              high while the effect is not idle (registered)
module screen_flash_fx #(
    parameter int NUM_PIXELS  = 6144,
    parameter int STEP_FRAMES = 1,
    parameter int HOLD_FRAMES = 4,
    parameter int PEAK_LEVEL  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] pixel_index,
    input  logic [15:0] bg_colour,
    input  logic        fx_trigger,
    output logic [15:0] oled_colour,
    output logic        fx_busy
);

    if (PEAK_LEVEL < 4 || PEAK_LEVEL > 16 || (PEAK_LEVEL % 4) != 0 ||
        STEP_FRAMES < 1 || HOLD_FRAMES < 1 || NUM_PIXELS < 2 || NUM_PIXELS > 8192) begin : g_bad_params
        $error("screen_flash_fx: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} state_t;

    localparam int SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_FRAMES - 1);
    // HOLD counts HOLD_FRAMES boundaries after the one that reached the peak,
    // and leaves on the following boundary.
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES);
    localparam logic [4:0]    PEAK      = 5'(PEAK_LEVEL);

    state_t        state, state_n;
    logic [4:0]    level, level_n;
    logic [SW-1:0] step_cnt, step_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic          pending, pending_n;
    logic [12:0]   prev_index;
    logic          frame_start;
    logic          pend_now;
    logic [4:0]    level_up;
    logic [4:0]    bumped;
    logic          busy_n;
    logic [15:0]   blended;

    function automatic logic [15:0] blend(input logic [15:0] c, input logic [4:0] l);
        logic [10:0] r_p, g_p, b_p;
        logic [4:0]  r, b;
        logic [5:0]  g;
        r_p = 11'(5'd31 - c[15:11]) * 11'(l);
        g_p = 11'(6'd63 - c[10:5]) * 11'(l);
        b_p = 11'(5'd31 - c[4:0]) * 11'(l);
        // c + ((max-c)*l)>>4 never exceeds max for l <= 16, so truncation is exact
        r = 5'(11'(c[15:11]) + (r_p >> 4));
        g = 6'(11'(c[10:5]) + (g_p >> 4));
        b = 5'(11'(c[4:0]) + (b_p >> 4));
        return {r, g, b};
    endfunction

    // A transition onto index 0 (including a mid-frame jump) starts a frame;
    // sitting on 0 does not re-fire.
    assign frame_start = (pixel_index == 13'd0) && (prev_index != 13'd0);
    assign pend_now    = pending | fx_trigger;
    assign level_up    = level + 5'd4;
    assign bumped      = (level_up > PEAK) ? PEAK : level_up;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            level       <= 5'd0;
            pending     <= 1'b0;
            step_cnt    <= '0;
            hold_cnt    <= '0;
            prev_index  <= 13'h1FFF;
            oled_colour <= 16'h0000;
            fx_busy     <= 1'b0;
        end else begin
            state       <= state_n;
            level       <= level_n;
            pending     <= pending_n;
            step_cnt    <= step_n;
            hold_cnt    <= hold_n;
            prev_index  <= pixel_index;
            oled_colour <= blended;
            fx_busy     <= busy_n;
        end
    end

    // Next-state logic; the level only moves on frame_start cycles.
    always_comb begin
        state_n   = state;
        level_n   = level;
        step_n    = step_cnt;
        hold_n    = hold_cnt;
        pending_n = pend_now;
        if (frame_start) begin
            if (pend_now) begin
                // Start or retrigger: build on the current level rather than restarting.
                pending_n = 1'b0;
                level_n   = bumped;
                step_n    = '0;
                hold_n    = '0;
                state_n   = (bumped == PEAK) ? HOLD : RISE;
            end else begin
                case (state)
                    RISE: begin
                        if (step_cnt == STEP_LAST) begin
                            step_n = '0;
                            if (level_up >= PEAK) begin
                                level_n = PEAK;
                                hold_n  = '0;
                                state_n = HOLD;
                            end else begin
                                level_n = level_up;
                            end
                        end else begin
                            step_n = step_cnt + SW'(1);
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            level_n = level - 5'd1;
                            step_n  = '0;
                            state_n = FALL;
                        end else begin
                            hold_n = hold_cnt + HW'(1);
                        end
                    end
                    FALL: begin
                        if (step_cnt == STEP_LAST) begin
                            step_n  = '0;
                            level_n = level - 5'd1;
                            if (level == 5'd1) begin
                                state_n = IDLE;
                            end
                        end else begin
                            step_n = step_cnt + SW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs: pixel 0 of a frame already sees the new level via level_n.
    always_comb begin
        busy_n  = (state_n != IDLE);
        blended = blend(bg_colour, level_n);
    end

endmodule

// File: tb/tb_screen_flash_fx.sv
module tb_screen_flash_fx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] pixel_index = 13'd0;
    logic [15:0] bg_colour = 16'h0000;
    logic        fx_trigger = 1'b0;
    wire  [15:0] oled_colour;
    wire         fx_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    screen_flash_fx dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_index(pixel_index),
        .bg_colour  (bg_colour),
        .fx_trigger (fx_trigger),
        .oled_colour(oled_colour),
        .fx_busy    (fx_busy)
    );

    // Hand-computed (31*L)>>4 and (63*L)>>4 for L = 0..16 (bg = black).
    logic [4:0] r_tab [17] = '{5'd0, 5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd15,
                               5'd17, 5'd19, 5'd21, 5'd23, 5'd25, 5'd27, 5'd29, 5'd31};
    logic [5:0] g_tab [17] = '{6'd0, 6'd3, 6'd7, 6'd11, 6'd15, 6'd19, 6'd23, 6'd27, 6'd31,
                               6'd35, 6'd39, 6'd43, 6'd47, 6'd51, 6'd55, 6'd59, 6'd63};
    // Required level per frame 1..24 after a trigger in frame 0 (index 0 unused).
    int lvl_seq [25] = '{0, 4, 8, 12, 16, 16, 16, 16, 16, 15, 14, 13, 12, 11, 10, 9,
                         8, 7, 6, 5, 4, 3, 2, 1, 0};

    function automatic logic [15:0] white_of(input int l);
        return {r_tab[l], g_tab[l], r_tab[l]};
    endfunction

    // One pixel cycle: drive, clock, settle; outputs then show this cycle's pixel.
    task automatic cyc(input logic [12:0] idx, input logic [15:0] bg, input logic trig);
        pixel_index = idx;
        bg_colour   = bg;
        fx_trigger  = trig;
        @(posedge clk);
        #1;
        fx_trigger  = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (oled_colour !== 16'h0000) begin
            errors++;
            $display("FAIL reset_oled got %h want 0000", oled_colour);
        end
        checks++;
        if (fx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", fx_busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_idle_pass;
        logic [15:0] bgs [6] = '{16'h8410, 16'hFFFF, 16'h1234, 16'h0001, 16'hF800, 16'h07E0};
        for (int i = 0; i < 6; i++) begin
            cyc(13'(i % 4), bgs[i], 1'b0);
            checks++;
            if (oled_colour !== bgs[i]) begin
                errors++;
                $display("FAIL idle_pass i%0d got %h want %h", i, oled_colour, bgs[i]);
            end
            checks++;
            if (fx_busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_busy i%0d got %b want 0", i, fx_busy);
            end
        end
        cyc(13'd2, 16'h0000, 1'b0);
        cyc(13'd3, 16'h0000, 1'b0);
    endtask

    task automatic test_flash_sequence;
        cyc(13'd0, 16'h0000, 1'b0);
        cyc(13'd1, 16'h0000, 1'b1);
        checks++;
        if (fx_busy !== 1'b0) begin
            errors++;
            $display("FAIL pend_busy got %b want 0", fx_busy);
        end
        cyc(13'd2, 16'h0000, 1'b0);
        cyc(13'd3, 16'h0000, 1'b0);
        for (int f = 1; f <= 24; f++) begin
            for (int p = 0; p < 4; p++) begin
                cyc(13'(p), 16'h0000, 1'b0);
                checks++;
                if (oled_colour !== white_of(lvl_seq[f])) begin
                    errors++;
                    $display("FAIL seq_oled f%0d p%0d got %h want %h", f, p, oled_colour, white_of(lvl_seq[f]));
                end
                checks++;
                if (fx_busy !== (f < 24)) begin
                    errors++;
                    $display("FAIL seq_busy f%0d p%0d got %b want %b", f, p, fx_busy, (f < 24));
                end
            end
        end
        checks++;
        if (white_of(lvl_seq[4]) !== 16'hFFFF || oled_colour !== 16'h0000) begin
            errors++;
            $display("FAIL seq_end got %h want 0000", oled_colour);
        end
    endtask

    task automatic test_coincident;
        // Trigger on the very boundary cycle: pixel 0 already at level 4.
        cyc(13'd0, 16'h0000, 1'b1);
        checks++;
        if (oled_colour !== 16'h39E7 || fx_busy !== 1'b1) begin
            errors++;
            $display("FAIL coinc_p0 got %h/%b want 39E7/1", oled_colour, fx_busy);
        end
        cyc(13'd1, 16'h0000, 1'b0);
        checks++;
        if (oled_colour !== 16'h39E7) begin
            errors++;
            $display("FAIL coinc_p1 got %h want 39E7", oled_colour);
        end
        cyc(13'd0, 16'h8410, 1'b0);
        checks++;
        if (oled_colour !== 16'hBDF7) begin
            errors++;
            $display("FAIL lvl8_8410 got %h want BDF7", oled_colour);
        end
        cyc(13'd1, 16'h0000, 1'b0);
        checks++;
        if (oled_colour !== 16'h7BEF) begin
            errors++;
            $display("FAIL lvl8_0000 got %h want 7BEF", oled_colour);
        end
    endtask

    task automatic test_hold_zero;
        // Index sits on 0 for 50 cycles: one step (8 -> 12) only.
        for (int i = 0; i < 50; i++) begin
            cyc(13'd0, 16'h0000, 1'b0);
            checks++;
            if (oled_colour !== 16'hBDF7) begin
                errors++;
                $display("FAIL hold0 c%0d got %h want BDF7", i, oled_colour);
            end
        end
        cyc(13'd1, 16'h0000, 1'b0);
        checks++;
        if (oled_colour !== 16'hBDF7) begin
            errors++;
            $display("FAIL hold0_p1 got %h want BDF7", oled_colour);
        end
        cyc(13'd0, 16'h0000, 1'b0);
        checks++;
        if (oled_colour !== 16'hFFFF) begin
            errors++;
            $display("FAIL hold0_next got %h want FFFF", oled_colour);
        end
    endtask

    task automatic test_retrigger;
        int pre  [8]  = '{16, 16, 16, 16, 15, 14, 13, 12};
        int post [12] = '{16, 16, 16, 16, 16, 15, 14, 13, 12, 11, 10, 9};
        for (int p = 1; p < 4; p++) cyc(13'(p), 16'h0000, 1'b0);
        for (int f = 0; f < 8; f++) begin
            for (int p = 0; p < 4; p++) begin
                cyc(13'(p), 16'h0000, (f == 7) && (p == 2));
                checks++;
                if (oled_colour !== white_of(pre[f])) begin
                    errors++;
                    $display("FAIL retrig_pre f%0d p%0d got %h want %h", f, p, oled_colour, white_of(pre[f]));
                end
            end
        end
        for (int f = 0; f < 12; f++) begin
            for (int p = 0; p < 4; p++) begin
                if (!((f == 11) && (p > 1))) begin
                    cyc(13'(p), 16'h0000, 1'b0);
                    checks++;
                    if (oled_colour !== white_of(post[f]) || fx_busy !== 1'b1) begin
                        errors++;
                        $display("FAIL retrig_post f%0d p%0d got %h/%b want %h/1", f, p, oled_colour, fx_busy, white_of(post[f]));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_fall;
        // Now mid-frame in FALL at level 9.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (oled_colour !== 16'h0000 || fx_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %h/%b want 0000/0", oled_colour, fx_busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(13'd0, 16'h8410, 1'b0);
        checks++;
        if (oled_colour !== 16'h8410 || fx_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_p0 got %h/%b want 8410/0", oled_colour, fx_busy);
        end
        cyc(13'd1, 16'h1234, 1'b0);
        checks++;
        if (oled_colour !== 16'h1234) begin
            errors++;
            $display("FAIL post_reset_p1 got %h want 1234", oled_colour);
        end
    endtask

    initial begin
        test_reset;
        test_idle_pass;
        test_flash_sequence;
        test_coincident;
        test_hold_zero;
        test_retrigger;
        test_reset_mid_fall;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
